// File: rtl/cordic_pkg.sv
// Shared widths, controller state encoding and result bundle for the CORDIC job controller.
package cordic_pkg;

    localparam int CORDIC_DATA_W = 16;
    localparam int CORDIC_PHI_W  = 8;
    localparam int CORDIC_IT_W   = 4;
    localparam int CORDIC_WDOG   = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Captured result: vector, accumulated angle and the timeout flag.
    typedef struct packed {
        logic [CORDIC_DATA_W-1:0]  x;
        logic [CORDIC_DATA_W-1:0]  y;
        logic [CORDIC_PHI_W+7:0]   deg;
        logic                      err;
    } result_t;

endpackage

// File: rtl/cordic_wdog.sv
// Clearable saturating cycle counter; expired_o flags the last allowed RUN cycle (count == WDOG-1).
module cordic_wdog #(
    parameter int WDOG  = 20,
    parameter int CNT_W = $clog2(WDOG + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over count; the counter parks at WDOG instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != CNT_W'(WDOG))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired_o = (r_cnt == CNT_W'(WDOG - 1));

endmodule

// File: rtl/cordic_ctrl.sv
// Job controller for cordic_datapath: accepts a job, starts the datapath, waits for the
// requested iteration count (or a watchdog timeout) and presents the captured result.
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int DATA_W = CORDIC_DATA_W,
    parameter int PHI_W  = CORDIC_PHI_W,
    parameter int IT_W   = CORDIC_IT_W,
    parameter int WDOG   = CORDIC_WDOG
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic [PHI_W-1:0]  phi_i,
    input  logic [IT_W-1:0]   num_it_i,
    output logic              dp_start_o,
    output logic [DATA_W-1:0] dp_x_o,
    output logic [DATA_W-1:0] dp_y_o,
    output logic [PHI_W-1:0]  dp_phi_o,
    output logic [IT_W-1:0]   dp_num_it_o,
    input  logic [IT_W-1:0]   dp_n_i,
    input  logic [DATA_W-1:0] dp_x_i,
    input  logic [DATA_W-1:0] dp_y_i,
    input  logic [PHI_W+7:0]  dp_deg_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] x_o,
    output logic [DATA_W-1:0] y_o,
    output logic [PHI_W+7:0]  deg_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [1:0]        dbg_state_o
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // valid never depends on ready, and ready/valid here decode only from the state register.

    state_t          r_state;
    state_t          w_next;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [PHI_W-1:0]  r_phi;
    logic [IT_W-1:0]   r_num_it;
    result_t         r_res;
    logic            w_accept;
    logic            w_match;
    logic            w_expired;
    logic            w_capture;

    assign w_accept  = (r_state == ST_IDLE) && in_valid_i;
    assign w_match   = (dp_n_i == r_num_it);
    assign w_capture = (r_state == ST_RUN) && (w_match || w_expired);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid_i) begin
                    w_next = (num_it_i != '0) ? ST_START : ST_DONE;
                end
            end
            ST_START: w_next = ST_RUN;
            ST_RUN: begin
                if (w_match || w_expired) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_x      <= '0;
            r_y      <= '0;
            r_phi    <= '0;
            r_num_it <= '0;
        end else if (w_accept) begin
            r_x      <= x_i;
            r_y      <= y_i;
            r_phi    <= phi_i;
            r_num_it <= num_it_i;
        end
    end

    // A zero-iteration job bypasses the datapath and returns the input vector unrotated.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_res <= '0;
        end else if (w_accept && (num_it_i == '0)) begin
            r_res.x   <= x_i;
            r_res.y   <= y_i;
            r_res.deg <= '0;
            r_res.err <= 1'b0;
        end else if (w_capture) begin
            r_res.x   <= dp_x_i;
            r_res.y   <= dp_y_i;
            r_res.deg <= dp_deg_i;
            r_res.err <= ~w_match;
        end
    end

    cordic_wdog #(
        .WDOG (WDOG)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (r_state == ST_START),
        .en_i      (r_state == ST_RUN),
        .expired_o (w_expired)
    );

    assign in_ready_o  = (r_state == ST_IDLE);
    assign out_valid_o = (r_state == ST_DONE);
    assign busy_o      = (r_state != ST_IDLE);
    assign dp_start_o  = (r_state == ST_START);
    assign dp_x_o      = r_x;
    assign dp_y_o      = r_y;
    assign dp_phi_o    = r_phi;
    assign dp_num_it_o = r_num_it;
    assign x_o         = r_res.x;
    assign y_o         = r_res.y;
    assign deg_o       = r_res.deg;
    assign err_o       = r_res.err;
    assign dbg_state_o = r_state;

endmodule

// File: doc/cordic_ctrl.md
# cordic_ctrl

Job controller in front of `cordic_datapath`: accepts one CORDIC job (x, y, phi, iteration count) over a valid/ready handshake and registers the operands. It pulses the datapath start, monitors its iteration counter until the requested count is reached, and captures the result into an output register. The result is presented over a second valid/ready handshake. It is the only block that drives the datapath's start and operand inputs.

## Interface
- DATA_W, 16, width of x/y operands and results
- PHI_W, 8, width of input angle (two's complement, MSB = sign)
- IT_W, 4, width of iteration count and datapath `n`
- WDOG, 20, max cycles in RUN before timeout
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  job offered
- in_ready_o  out  1  job can be accepted
- x_i, y_i  in  DATA_W  start vector
- phi_i  in  PHI_W  target angle
- num_it_i  in  IT_W  requested iterations
- dp_start_o  out  1  one-cycle start pulse to datapath
- dp_x_o, dp_y_o  out  DATA_W  registered operands to datapath
- dp_phi_o  out  PHI_W  registered angle to datapath
- dp_num_it_o  out  IT_W  registered iteration count to datapath
- dp_n_i  in  IT_W  datapath iteration counter (`eab_o`)
- dp_x_i, dp_y_i  in  DATA_W  datapath vector result
- dp_deg_i  in  PHI_W+8  datapath accumulated angle
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer takes result
- x_o, y_o  out  DATA_W  result vector
- deg_o  out  PHI_W+8  result angle
- err_o  out  1  result produced by watchdog timeout
- busy_o  out  1  high in any state other than IDLE

## Operation
- States: IDLE, START, RUN, DONE.
- IDLE: `in_ready_o`=1. On `in_valid_i & in_ready_o`, register x, y, phi, num_it into the dp_* operand registers. If `num_it_i`!=0, go to START. If `num_it_i`==0, load x_o=x_i, y_o=y_i, deg_o=0, err_o=0 and go to DONE; the datapath is not started.
- START: `dp_start_o`=1 for exactly this cycle. Clear the watchdog counter. Go to RUN.
- RUN: increment the watchdog counter each cycle.
  - If `dp_n_i == dp_num_it_o`, capture dp_x_i/dp_y_i/dp_deg_i into x_o/y_o/deg_o, err_o=0, and go to DONE.
  - Else, if the counter reaches WDOG-1, capture the same signals, err_o=1, and go to DONE.
  - The match check has priority over the timeout in the same cycle.
- DONE: `out_valid_o`=1. x_o/y_o/deg_o/err_o are held stable. On `out_ready_i`, go to IDLE.
- The dp_* operand registers stay stable from acceptance until the next acceptance.
- No bypass: `in_ready_o` is 0 in DONE even when `out_ready_i`=1, so the earliest next acceptance is the cycle after the result handshake.
- All compares are unsigned on IT_W bits. The watchdog counter is $clog2(WDOG+1) bits and saturates; it does not wrap.

## Timing
- Reset values:
  - state=IDLE, `in_ready_o`=1
  - `dp_start_o`=0, `out_valid_o`=0, `err_o`=0, `busy_o`=0
  - all data outputs and dp_* operand registers = 0
  - watchdog counter = 0
- Reset asserted in any state returns the block to IDLE immediately (asynchronous). Any pending result is discarded. `dp_start_o` drops in the same instant.
- Acceptance at cycle t gives `dp_start_o` high at t+1 and RUN from t+2.
- With the datapath's counter reaching N at cycle t+2+k, `out_valid_o` rises at t+3+k.
- num_it=0 path: acceptance at t, `out_valid_o` at t+1.
- Outputs are registered; `in_ready_o`, `busy_o` and `out_valid_o` are decoded from the state register only.

## Structure
- `cordic_pkg` holds:
  - DATA_W, PHI_W and IT_W defaults
  - the state enum (IDLE/START/RUN/DONE)
  - the result bundle typedef (x, y, deg, err)
- One sub-module, `cordic_wdog`: clearable saturating cycle counter with a `expired_o` compare output at WDOG-1. The FSM, operand registers and result registers stay in `cordic_ctrl`.

## Test plan
- Job x=0x4000, y=0, phi=0x20, num_it=8, datapath model raising n by 1 per cycle from START+1:
  - one `dp_start_o` pulse at t+1
  - `out_valid_o` at t+11
  - x_o/y_o/deg_o equal to the model values at n=8, err_o=0
- num_it=0, x=0x1234, y=0x5678 -> `out_valid_o` at t+1, x_o=0x1234, y_o=0x5678, deg_o=0, `dp_start_o` never asserted.
- Datapath model with n stuck at 0, num_it=5, WDOG=20 -> `out_valid_o` 21 cycles after START, err_o=1.
- Hold `out_ready_i`=0 for 10 cycles in DONE with `in_valid_i`=1 and changing inputs:
  - outputs stable, `in_ready_o`=0
  - after `out_ready_i`, next acceptance one cycle later with the new operands
- Assert `rst_i` mid-RUN (n=3 of 8) -> all outputs at their reset values immediately; the next job completes normally.
- Back-to-back jobs with `out_ready_i` tied high -> exactly one start pulse per job, operands never change during RUN.
